// File: rtl/r_fifo_arbiter_pkg.sv
// Shared types and helpers for the R-channel FIFO arbiter and its round-robin picker.
package r_arb_pkg;

    typedef enum logic {
        R_ARB_IDLE,
        R_ARB_BURST
    } r_arb_state_e;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // Next index in a ring of n entries.
    function automatic int rr_next(input int cur, input int n);
        if (cur + 1 >= n) begin
            return 0;
        end
        return cur + 1;
    endfunction

endpackage

// File: rtl/r_fifo_arbiter_if.sv
// Bundle of per-source FIFO fronts and the shared master R channel.
// RID width widens by the source-index width when R_ARB_SRC_TAG_EN is defined.
interface r_fifo_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int SRC_W = $clog2(NUM_SRC);
`ifdef R_ARB_SRC_TAG_EN
    localparam int RID_W = SRC_W + ID_WIDTH;
`else
    localparam int RID_W = ID_WIDTH;
`endif

    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC*ID_WIDTH-1:0]   src_RID;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_RDATA;
    logic [NUM_SRC*2-1:0]          src_RRESP;
    logic [NUM_SRC-1:0]            src_RLAST;
    logic [NUM_SRC-1:0]            src_pop;

    logic                  RVALID;
    logic                  RREADY;
    logic [RID_W-1:0]      RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;

    modport master (
        input  src_valid, src_RID, src_RDATA, src_RRESP, src_RLAST, RREADY,
        output src_pop, RVALID, RID, RDATA, RRESP, RLAST
    );

    modport slave (
        output src_valid, src_RID, src_RDATA, src_RRESP, src_RLAST, RREADY,
        input  src_pop, RVALID, RID, RDATA, RRESP, RLAST
    );

endinterface

// File: rtl/r_fifo_arbiter_rr_pick.sv
// Combinational rotate-priority search: first set request after index 'last', wrapping.
module rr_pick
    import r_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int W = $clog2(N);

    int pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = int'(last);
        for (int k = 0; k < N; k++) begin
            pos = rr_next(pos, N);
            if (!found && req[W'(pos)]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/r_fifo_arbiter.sv
// Round-robin, burst-locked sharing of one master R channel among NUM_SRC response FIFOs.
// R_ARB_SRC_TAG_EN defined: RID carries the granted source index in its MSBs.
module r_fifo_arbiter
    import r_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    r_fifo_arbiter_if.master           bus,
    output logic                       busy,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx
);
    localparam int SRC_W = $clog2(NUM_SRC);

    r_arb_state_e     state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;

    logic [SRC_W-1:0] pick_idx;
    logic             pick_found;
    logic             beat_hs;

    logic [ID_WIDTH-1:0]   rid_arr   [NUM_SRC];
    logic [DATA_WIDTH-1:0] rdata_arr [NUM_SRC];
    logic [1:0]            rresp_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign rid_arr[i]   = bus.src_RID[i*ID_WIDTH +: ID_WIDTH];
        assign rdata_arr[i] = bus.src_RDATA[i*DATA_WIDTH +: DATA_WIDTH];
        assign rresp_arr[i] = bus.src_RRESP[i*2 +: 2];
    end

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req   (bus.src_valid),
        .last  (last_grant_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= R_ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_hs      = 1'b0;
        bus.src_pop  = '0;
        bus.RVALID   = 1'b0;
        bus.RID      = '0;
        bus.RDATA    = '0;
        bus.RRESP    = '0;
        bus.RLAST    = 1'b0;

        case (state_q)
            R_ARB_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = R_ARB_BURST;
                end
            end
            R_ARB_BURST: begin
                // Outputs are suppressed during reset so an aborted burst never pops.
                if (!ARESET) begin
                    bus.RVALID = bus.src_valid[grant_q];
`ifdef R_ARB_SRC_TAG_EN
                    bus.RID    = {grant_q, rid_arr[grant_q]};
`else
                    bus.RID    = rid_arr[grant_q];
`endif
                    bus.RDATA  = rdata_arr[grant_q];
                    bus.RRESP  = rresp_arr[grant_q];
                    bus.RLAST  = bus.src_RLAST[grant_q];
                    beat_hs    = bus.src_valid[grant_q] & bus.RREADY;
                    bus.src_pop[grant_q] = beat_hs;
                end
                if (beat_hs && bus.src_RLAST[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = R_ARB_IDLE;
                end
            end
            default: begin
                state_d = R_ARB_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == R_ARB_BURST) && !ARESET;
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_r_fifo_arbiter.sv
// Scoreboard bench for r_fifo_arbiter: modelled source FIFOs, directed bursts, monitor on R handshakes.
module tb_r_fifo_arbiter;
    import r_arb_pkg::*;

    localparam int NS = 4;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int SW = 2;
`ifdef R_ARB_SRC_TAG_EN
    localparam int RW = SW + IW;
`else
    localparam int RW = IW;
`endif

    typedef struct packed {
        logic [IW-1:0] rid;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [SW-1:0] src;
        beat_t         b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          busy;
    logic [SW-1:0] grant_idx;

    r_fifo_arbiter_if #(.NUM_SRC(NS), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

    r_fifo_arbiter #(.NUM_SRC(NS), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .ACLK      (clk),
        .ARESET    (rst),
        .bus       (bus.master),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    beat_t       fq [NS][$];
    logic [NS-1:0] dry;
    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int fifo_total();
        int s = 0;
        for (int i = 0; i < NS; i++) s += fq[i].size();
        return s;
    endfunction

    task automatic refresh();
        for (int i = 0; i < NS; i++) begin
            beat_t b;
            b = (fq[i].size() > 0) ? fq[i][0] : '0;
            bus.src_valid[i]           = (fq[i].size() > 0) && !dry[i];
            bus.src_RID[i*IW +: IW]    = b.rid;
            bus.src_RDATA[i*DW +: DW]  = b.data;
            bus.src_RRESP[i*2 +: 2]    = b.resp;
            bus.src_RLAST[i]           = b.last;
        end
    endtask

    // Pops are sampled on the falling edge, applied just after the rising edge.
    task automatic cycle();
        logic [NS-1:0] pop;
        @(negedge clk);
        pop = bus.src_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        refresh();
    endtask

    task automatic load(input int s, input int n, input logic [IW-1:0] rid, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.rid  = rid;
            b.data = base + DW'(k);
            b.resp = k[1:0];
            b.last = (k == n - 1);
            fq[s].push_back(b);
        end
    endtask

    task automatic expect_beats(input int s, input int n, input int total, input logic [IW-1:0] rid,
                                input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.src    = SW'(s);
            e.b.rid  = rid;
            e.b.data = base + DW'(k);
            e.b.resp = k[1:0];
            e.b.last = (k == total - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while (c < budget && !(fifo_total() == 0 && exp_q.size() == 0)) begin
            cycle();
            c++;
        end
        check(name, 64'(fifo_total() == 0 && exp_q.size() == 0), 64'd1);
    endtask

    // Monitor: every accepted beat is compared against the scoreboard head.
    always @(negedge clk) begin
        exp_t          e;
        logic [RW-1:0] rid_req;
        if (bus.RVALID && bus.RREADY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got RID %0h RDATA %0h, expected no beat", bus.RID, bus.RDATA);
            end else begin
                e = exp_q.pop_front();
`ifdef R_ARB_SRC_TAG_EN
                rid_req = {e.src, e.b.rid};
`else
                rid_req = e.b.rid;
`endif
                check("mon_grant", 64'(grant_idx), 64'(e.src));
                check("mon_rid",   64'(bus.RID), 64'(rid_req));
                check("mon_rdata", 64'(bus.RDATA), 64'(e.b.data));
                check("mon_rresp", 64'(bus.RRESP), 64'(e.b.resp));
                check("mon_rlast", 64'(bus.RLAST), 64'(e.b.last));
                check("mon_pop",   64'(bus.src_pop), 64'(1) << e.src);
            end
        end else begin
            check("mon_nopop", 64'(bus.src_pop), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        dry        = '0;
        bus.RREADY = 1'b1;
        refresh();

        // Reset with all four sources requesting; source 0 holds two single-beat bursts.
        load(0, 1, 4'h1, 32'h0000_0100);
        load(1, 1, 4'h2, 32'h0000_0200);
        load(2, 1, 4'h3, 32'h0000_0300);
        load(3, 1, 4'h4, 32'h0000_0400);
        load(0, 1, 4'h5, 32'h0000_0500);
        refresh();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_rvalid", 64'(bus.RVALID), 64'd0);
            check("rst_pop",    64'(bus.src_pop), 64'd0);
            check("rst_busy",   64'(busy), 64'd0);
        end
        check("rst_grant", 64'(grant_idx), 64'd0);
        check("rst_fifo",  64'(fifo_total()), 64'd5);

        expect_beats(0, 1, 1, 4'h1, 32'h0000_0100);
        expect_beats(1, 1, 1, 4'h2, 32'h0000_0200);
        expect_beats(2, 1, 1, 4'h3, 32'h0000_0300);
        expect_beats(3, 1, 1, 4'h4, 32'h0000_0400);
        expect_beats(0, 1, 1, 4'h5, 32'h0000_0500);
        rst = 1'b0;
        cycle();
        check("rr_first_grant",  64'(grant_idx), 64'd0);
        check("rr_first_busy",   64'(busy), 64'd1);
        check("rr_first_rvalid", 64'(bus.RVALID), 64'd1);
        for (int i = 0; i < 8; i++) cycle();
        check("rr_bubble_left", 64'(fifo_total()), 64'd1);
        cycle();
        check("rr_done_fifo", 64'(fifo_total()), 64'd0);
        check("rr_done_exp",  64'(exp_q.size()), 64'd0);
        check("rr_done_busy", 64'(busy), 64'd0);

        // Burst lock: source 1 four beats, source 2 waiting the whole time.
        load(1, 4, 4'h7, 32'h0000_1000);
        load(2, 1, 4'h9, 32'h0000_2000);
        expect_beats(1, 4, 4, 4'h7, 32'h0000_1000);
        expect_beats(2, 1, 1, 4'h9, 32'h0000_2000);
        refresh();
        cycle();
        check("lock_grant", 64'(grant_idx), 64'd1);
        drain("lock_drain", 40);

        // Backpressure in the middle of a source-3 burst.
        load(3, 3, 4'hC, 32'h0000_3000);
        expect_beats(3, 3, 3, 4'hC, 32'h0000_3000);
        refresh();
        cycle();
        check("bp_grant", 64'(grant_idx), 64'd3);
        cycle();
        bus.RREADY = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", 64'(bus.RVALID), 64'd1);
            check("bp_rdata",  64'(bus.RDATA), 64'h0000_3001);
            check("bp_pop",    64'(bus.src_pop), 64'd0);
            cycle();
        end
        check("bp_fifo_held", 64'(fq[3].size()), 64'd2);
        bus.RREADY = 1'b1;
        #1;
        check("bp_pop_rise", 64'(bus.src_pop), 64'b1000);
        drain("bp_drain", 40);

        // Source 0 runs dry after two beats while source 3 requests.
        load(0, 4, 4'h3, 32'h0000_4000);
        load(3, 1, 4'hE, 32'h0000_5000);
        expect_beats(0, 4, 4, 4'h3, 32'h0000_4000);
        expect_beats(3, 1, 1, 4'hE, 32'h0000_5000);
        refresh();
        cycle();
        cycle();
        cycle();
        dry[0] = 1'b1;
        refresh();
        #1;
        for (int i = 0; i < 3; i++) begin
            check("dry_rvalid", 64'(bus.RVALID), 64'd0);
            check("dry_grant",  64'(grant_idx), 64'd0);
            check("dry_busy",   64'(busy), 64'd1);
            cycle();
        end
        check("dry_fifo", 64'(fq[0].size()), 64'd2);
        dry[0] = 1'b0;
        refresh();
        drain("dry_drain", 40);

        // Reset after the first beat of a source-2 burst.
        load(2, 3, 4'hA, 32'h0000_6000);
        expect_beats(2, 1, 3, 4'hA, 32'h0000_6000);
        refresh();
        cycle();
        #1;
`ifdef R_ARB_SRC_TAG_EN
        check("tag_rid", 64'(bus.RID), 64'h2A);
`else
        check("tag_rid", 64'(bus.RID), 64'hA);
`endif
        cycle();
        rst = 1'b1;
        #1;
        check("mid_rvalid", 64'(bus.RVALID), 64'd0);
        check("mid_pop",    64'(bus.src_pop), 64'd0);
        check("mid_busy",   64'(busy), 64'd0);
        cycle();
        check("mid_nopop_fifo", 64'(fq[2].size()), 64'd2);
        check("mid_idle_busy",  64'(busy), 64'd0);
        check("mid_exp",        64'(exp_q.size()), 64'd0);
        fq[2].delete();
        load(1, 1, 4'h6, 32'h0000_7000);
        load(2, 1, 4'h8, 32'h0000_7100);
        expect_beats(1, 1, 1, 4'h6, 32'h0000_7000);
        expect_beats(2, 1, 1, 4'h8, 32'h0000_7100);
        refresh();
        rst = 1'b0;
        cycle();
        check("post_rst_grant", 64'(grant_idx), 64'd1);
        drain("post_rst_drain", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
